vx_miss_track: RTL

Per-bank miss-status holding table sitting directly downstream of the cache tag-access stage. A request that misses there (tag_match low) is parked here with its line address and request metadata. Duplicate misses to a line with a memory request already outstanding are flagged so only one memory request is issued. When the fill for that line returns, all parked requests for it become ready and are replayed, one per cycle, back into the bank pipeline.

---
 rtl/vx_miss_track_pkg.sv | 21 ++
 rtl/vx_miss_track_rr_find.sv | 29 ++
 rtl/vx_miss_track.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vx_miss_track_pkg.sv
// Shared cache-bank types for the miss-status holding table.
// LINE_ADDR_WIDTH falls back to 26 bits when the build does not provide it.
`ifndef LINE_ADDR_WIDTH
`define LINE_ADDR_WIDTH 26
`endif

package vx_miss_track_pkg;

    localparam int MSHR_SIZE_DEF = 8;
    localparam int MSHR_ID_BITS  = $clog2(MSHR_SIZE_DEF);
    localparam int MSHR_ADDR_W   = `LINE_ADDR_WIDTH;
    localparam int MSHR_DATA_W   = 64;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic [MSHR_ADDR_W-1:0] addr;
        logic [MSHR_DATA_W-1:0] data;
    } mshr_entry_t;

endpackage

// File: rtl/vx_miss_track_rr_find.sv
// Combinational rotating-priority first-set finder: scans vec_i starting at start_i
// and wrapping modulo N; returns whether any bit is set and the first one found.
module vx_miss_track_rr_find #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    logic [IW-1:0] j;

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            // N is a power of two, so the IW-bit add wraps naturally.
            j = start_i + IW'(k);
            if (!found_o && vec_i[j]) begin
                found_o = 1'b1;
                index_o = j;
            end
        end
    end

endmodule

// File: rtl/vx_miss_track.sv
// Per-bank miss-status holding table: parks tag misses, flags duplicate misses and
// replays filled requests oldest-first. VX_MISS_TRACK_PERF_EN adds perf_full_stalls.
module vx_miss_track
    import vx_miss_track_pkg::*;
#(
    parameter int MSHR_SIZE = MSHR_SIZE_DEF,
    parameter int ADDRW     = MSHR_ADDR_W,
    parameter int DATAW     = MSHR_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    input  logic [ADDRW-1:0]             alloc_addr,
    input  logic [DATAW-1:0]             alloc_data,
    output logic                         alloc_ready,
    output logic [$clog2(MSHR_SIZE)-1:0] alloc_id,
    output logic                         alloc_pending,
    input  logic                         fill_valid,
    input  logic [ADDRW-1:0]             fill_addr,
    output logic                         deq_valid,
    output logic [ADDRW-1:0]             deq_addr,
    output logic [DATAW-1:0]             deq_data,
    output logic [$clog2(MSHR_SIZE)-1:0] deq_id,
    input  logic                         deq_ready
`ifdef VX_MISS_TRACK_PERF_EN
    ,
    output logic [63:0]                  perf_full_stalls
`endif
);

    localparam int ID_W = $clog2(MSHR_SIZE);
    localparam int CW   = ID_W + 1;

    mshr_entry_t entries_q [MSHR_SIZE];
    mshr_entry_t entries_d [MSHR_SIZE];
    logic [ID_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [MSHR_SIZE-1:0] rdy_vec;
    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic                 pending;
    logic                 alloc_fire, deq_fire;

    always_comb begin
        rdy_vec = '0;
        pending = 1'b0;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            rdy_vec[i] = entries_q[i].valid && entries_q[i].ready;
            if (entries_q[i].valid && !entries_q[i].ready && entries_q[i].addr == alloc_addr)
                pending = 1'b1;
        end
    end

    vx_miss_track_rr_find #(.N(MSHR_SIZE), .IW(ID_W)) u_deq_sel (
        .vec_i   (rdy_vec),
        .start_i (head_q),
        .found_o (win_found),
        .index_o (win_idx)
    );

    // No bypass from a same-cycle dequeue: readiness comes from registered state only.
    assign alloc_ready   = !entries_q[tail_q].valid;
    assign alloc_id      = tail_q;
    assign alloc_pending = pending;
    assign deq_valid     = win_found;
    assign deq_addr      = entries_q[win_idx].addr;
    assign deq_data      = entries_q[win_idx].data;
    assign deq_id        = win_idx;

    assign alloc_fire = alloc_valid && alloc_ready;
    assign deq_fire   = win_found && deq_ready;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (fill_valid) begin
            for (int i = 0; i < MSHR_SIZE; i++) begin
                if (entries_q[i].valid && entries_q[i].addr == fill_addr)
                    entries_d[i].ready = 1'b1;
            end
        end
        if (deq_fire)
            entries_d[win_idx].valid = 1'b0;
        // The tail slot is invalid whenever alloc fires, so it never collides with the winner.
        if (alloc_fire) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].ready = fill_valid && (fill_addr == alloc_addr);
            entries_d[tail_q].addr  = alloc_addr;
            entries_d[tail_q].data  = alloc_data;
            tail_d                  = tail_q + ID_W'(1);
        end
        if (alloc_fire && !deq_fire)
            count_d = count_q + CW'(1);
        else if (!alloc_fire && deq_fire)
            count_d = count_q - CW'(1);
        if (!entries_q[head_q].valid && count_q != '0)
            head_d = head_q + ID_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSHR_SIZE; i++)
                entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

`ifdef VX_MISS_TRACK_PERF_EN
    logic [63:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset)
            perf_q <= '0;
        else if (alloc_valid && !alloc_ready)
            perf_q <= perf_q + 64'd1;
    end

    assign perf_full_stalls = perf_q;
`endif

endmodule
